// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard/stall/flush controller for a five-stage pipeline
// Only the run/wait/halt state and the frozen-cycle counter are stored; all controls are combinational.
module pipeline_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_mem_read_ex,
    input  logic [2:0]  rd_ex,
    input  logic [2:0]  rs_id,
    input  logic [2:0]  rd_id,
    input  logic        use_rs_id,
    input  logic        use_rd_id,
    input  logic        branch_taken_ex,
    input  logic        halt_wb,
    input  logic        mem_busy,
    input  logic        start,
    output logic        en_pc,
    output logic        en_if_id,
    output logic        en_id_ex,
    output logic        en_ex_mem,
    output logic        en_mem_wb,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        halted,
    output logic [1:0]  state,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        S_RUN      = 2'b00,
        S_WAIT     = 2'b01,
        S_HALT     = 2'b10,
        S_HALT_ALT = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic        load_use;

    assign load_use = op_mem_read_ex &&
                      ((use_rs_id && (rs_id == rd_ex)) || (use_rd_id && (rd_id == rd_ex)));

    always_comb begin
        state_d     = state_q;
        en_pc       = 1'b0;
        en_if_id    = 1'b0;
        en_id_ex    = 1'b0;
        en_ex_mem   = 1'b0;
        en_mem_wb   = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        halted      = 1'b0;
        case (state_q)
            S_RUN: begin
                if (halt_wb) begin
                    state_d = S_HALT;
                end else if (mem_busy) begin
                    // A coincident branch or hazard is frozen and re-evaluated after the wait.
                    state_d = S_WAIT;
                end else if (branch_taken_ex) begin
                    en_pc       = 1'b1;
                    en_if_id    = 1'b1;
                    en_id_ex    = 1'b1;
                    en_ex_mem   = 1'b1;
                    en_mem_wb   = 1'b1;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (load_use) begin
                    en_id_ex    = 1'b1;
                    en_ex_mem   = 1'b1;
                    en_mem_wb   = 1'b1;
                    flush_id_ex = 1'b1;
                end else begin
                    en_pc     = 1'b1;
                    en_if_id  = 1'b1;
                    en_id_ex  = 1'b1;
                    en_ex_mem = 1'b1;
                    en_mem_wb = 1'b1;
                end
            end
            S_WAIT: begin
                if (!mem_busy) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                halted = 1'b1;
                if (start) begin
                    state_d = S_RUN;
                end
            end
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!en_pc && !halted && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_RUN;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign state       = state_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        op_mem_read_ex = 1'b0;
    logic [2:0]  rd_ex = 3'd0;
    logic [2:0]  rs_id = 3'd0;
    logic [2:0]  rd_id = 3'd0;
    logic        use_rs_id = 1'b0;
    logic        use_rd_id = 1'b0;
    logic        branch_taken_ex = 1'b0;
    logic        halt_wb = 1'b0;
    logic        mem_busy = 1'b0;
    logic        start = 1'b0;
    logic        en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic        flush_if_id, flush_id_ex, halted;
    logic [1:0]  state;
    logic [15:0] stall_count;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: mode 0=run, 1=wait, 2=halt; counter kept as a plain integer.
    int m_mode = 0;
    int m_cnt  = 0;

    pipeline_ctrl dut (
        .clock(clock), .reset(reset), .op_mem_read_ex(op_mem_read_ex), .rd_ex(rd_ex),
        .rs_id(rs_id), .rd_id(rd_id), .use_rs_id(use_rs_id), .use_rd_id(use_rd_id),
        .branch_taken_ex(branch_taken_ex), .halt_wb(halt_wb), .mem_busy(mem_busy),
        .start(start), .en_pc(en_pc), .en_if_id(en_if_id), .en_id_ex(en_id_ex),
        .en_ex_mem(en_ex_mem), .en_mem_wb(en_mem_wb), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .halted(halted), .state(state), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit hazard();
        bit hit_rs, hit_rd;
        hit_rs = use_rs_id && (rs_id == rd_ex);
        hit_rd = use_rd_id && (rd_id == rd_ex);
        return op_mem_read_ex && (hit_rs || hit_rd);
    endfunction

    // Expected {en_pc,en_if_id,en_id_ex,en_ex_mem,en_mem_wb,flush_if_id,flush_id_ex,halted}
    function automatic logic [7:0] exp_ctl(input int mode);
        if (mode == 2)                 return 8'b00000_00_1;
        if (mode == 1)                 return 8'b00000_00_0;
        if (halt_wb || mem_busy)       return 8'b00000_00_0;
        if (branch_taken_ex)           return 8'b11111_11_0;
        if (hazard())                  return 8'b00111_01_0;
        return 8'b11111_00_0;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_mode <= 0;
            m_cnt  <= 0;
        end else begin
            if (exp_ctl(m_mode)[7] == 1'b0 && m_mode != 2 && m_cnt < 65535)
                m_cnt <= m_cnt + 1;
            case (m_mode)
                0:       m_mode <= halt_wb ? 2 : (mem_busy ? 1 : 0);
                1:       m_mode <= mem_busy ? 1 : 0;
                default: m_mode <= start ? 0 : 2;
            endcase
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("outputs",
                {6'd0, en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id,
                 flush_id_ex, halted, state, stall_count},
                {6'd0, exp_ctl(m_mode), m_mode[1:0], m_cnt[15:0]});
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        op_mem_read_ex = 0; rd_ex = 0; rs_id = 0; rd_id = 0; use_rs_id = 0; use_rd_id = 0;
        branch_taken_ex = 0; halt_wb = 0; mem_busy = 0; start = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        #1;
        chk("reset_state", {14'd0, state, stall_count}, 32'd0);
        chk("reset_ctl", {24'd0, en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                          flush_if_id, flush_id_ex, halted}, {24'd0, 8'b11111_00_0});
        step();
        reset = 0;
    endtask

    initial begin
        #1;
        do_reset();
        chk_en = 1;

        // Load-use via rs
        op_mem_read_ex = 1; rd_ex = 3; rs_id = 3; use_rs_id = 1;
        #2;
        chk("lu_en_pc", en_pc, 0);
        chk("lu_en_if_id", en_if_id, 0);
        chk("lu_flush_id_ex", flush_id_ex, 1);
        step();
        idle();
        chk("lu_count", stall_count, 1);
        step();
        chk("lu_count_after", stall_count, 1);
        // Register 0 via rd field, then same regs without use flags
        op_mem_read_ex = 1; rd_ex = 0; rd_id = 0; use_rd_id = 1;
        step();
        use_rd_id = 0; rs_id = 0;
        step();
        chk("lu_r0_count", stall_count, 2);
        idle();

        // Branch + hazard
        do_reset();
        op_mem_read_ex = 1; rd_ex = 5; rs_id = 5; use_rs_id = 1; branch_taken_ex = 1;
        #2;
        chk("br_flush_if_id", flush_if_id, 1);
        chk("br_flush_id_ex", flush_id_ex, 1);
        chk("br_en_pc", en_pc, 1);
        step();
        chk("br_count", stall_count, 0);
        idle();

        // Memory wait: busy for three edges
        do_reset();
        mem_busy = 1;
        step();
        chk("mw_state_wait", state, 2'b01);
        step();
        step();
        mem_busy = 0;
        #2;
        chk("mw_en_resume", en_pc, 0);
        step();
        chk("mw_state_run", state, 2'b00);
        chk("mw_count", stall_count, 4);

        // Branch frozen by busy, then re-evaluated in RUN
        do_reset();
        branch_taken_ex = 1; mem_busy = 1;
        #2;
        chk("bb_flush_frozen", flush_if_id, 0);
        step();
        mem_busy = 0;
        step();
        #2;
        chk("bb_flush_after", flush_if_id, 1);
        step();
        idle();

        // Halt / restart, start ignored in RUN
        do_reset();
        start = 1;
        step();
        start = 0; halt_wb = 1;
        step();
        halt_wb = 0;
        chk("h_state", state, 2'b10);
        chk("h_halted", halted, 1);
        chk("h_count", stall_count, 1);
        step();
        step();
        chk("h_count_frozen", stall_count, 1);
        start = 1;
        step();
        start = 0;
        chk("h_state_run", state, 2'b00);
        chk("h_en_all", {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb}, 5'b11111);

        // Saturation
        do_reset();
        mem_busy = 1;
        repeat (70000) step();
        chk("sat_count", stall_count, 16'hFFFF);
        step();
        chk("sat_hold", stall_count, 16'hFFFF);

        // Async reset mid-WAIT
        do_reset();
        mem_busy = 1;
        step();
        step();
        chk("ar_pre_count", stall_count, 2);
        #2;
        reset = 1;
        #1;
        chk("ar_state", state, 2'b00);
        chk("ar_count", stall_count, 0);
        step();
        reset = 0;
        step();
        chk("ar_resample", state, 2'b01);
        mem_busy = 0;
        step();
        step();

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 SHALL have these ports, name / direction / width / meaning:
- clock  in  1  rising-edge clock
- reset  in  1  async active-high reset
- op_mem_read_ex  in  1  EX-stage instruction is a load
- rd_ex  in  3  EX-stage destination register
- rs_id, rd_id  in  3 each  ID-stage source register fields
- use_rs_id, use_rd_id  in  1 each  ID instruction reads that field
- branch_taken_ex  in  1  taken branch/jump resolved in EX
- halt_wb  in  1  halt instruction in WB
- mem_busy  in  1  data memory not ready
- start  in  1  restart pulse, leaves HALT
- en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb  out  1 each  stage load enable; 0 = hold
- flush_if_id, flush_id_ex  out  1 each  load bubble (all-zero controls); overrides enable
- halted  out  1  state is HALT
- state  out  2  RUN=00, WAIT=01, HALT=10
- stall_count  out  16  saturating count of frozen cycles

Function
REQ-003 SHALL hold only state and stall_count in flops; all other outputs are combinational from state and current inputs.
REQ-004 SHALL define load_use = op_mem_read_ex AND ((use_rs_id AND rs_id==rd_ex) OR (use_rd_id AND rd_id==rd_ex)); register 0 is not special.
REQ-005 In RUN, SHALL evaluate by priority: halt_wb > mem_busy > branch_taken_ex > load_use > normal.
REQ-006 RUN, halt_wb=1: en_pc, en_if_id, en_id_ex, en_ex_mem = 0; en_mem_wb = 0; next state HALT.
REQ-007 RUN, mem_busy=1 (no halt): all five enables 0, flushes 0; next state WAIT.
REQ-008 RUN, branch_taken_ex=1: all enables 1, flush_if_id=1, flush_id_ex=1; state stays RUN; load_use ignored that cycle.
REQ-009 RUN, load_use=1: en_pc=0, en_if_id=0, flush_id_ex=1, en_ex_mem=1, en_mem_wb=1; exactly one bubble per hazard, since the load leaves EX next cycle.
REQ-010 RUN, none of the above: all enables 1, flushes 0.
REQ-011 WAIT: all enables 0 and flushes 0 unconditionally; next state RUN when mem_busy=0, else WAIT. Resume costs one extra frozen cycle, and memory SHALL hold data across that cycle.
REQ-012 HALT: all enables 0, flushes 0, halted=1; next state RUN when start=1, else HALT. start is ignored outside HALT.
REQ-013 A branch or load-use coinciding with mem_busy SHALL be frozen, not acted on; it is re-evaluated in the first RUN cycle after WAIT.
REQ-014 stall_count SHALL increment by 1 on each clock edge where en_pc=0 and state!=HALT, saturate at 16'hFFFF, and never wrap.
REQ-015 Encodings 11 of state SHALL be treated as HALT.

Reset
REQ-016 reset=1 SHALL immediately force state=RUN (00) and stall_count=0, regardless of clock.
REQ-017 With reset=1 and idle inputs: all enables 1, flushes 0, halted 0.
REQ-018 Reset asserted in WAIT or HALT SHALL abandon that state; a pending mem_busy is re-sampled after release.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Load-use: op_mem_read_ex=1, rd_ex=3, rs_id=3, use_rs_id=1 -> one cycle with en_pc=0, en_if_id=0, flush_id_ex=1; stall_count=1.
- Branch + hazard: branch_taken_ex=1 with the load-use condition true -> flush_if_id=1, flush_id_ex=1, en_pc=1; stall_count unchanged.
- Memory wait: mem_busy=1 for 3 cycles from RUN -> WAIT entered; enables 0 for 4 cycles total; then RUN; stall_count=4.
- Halt/restart: halt_wb=1 -> HALT, halted=1, stall_count frozen; start pulse -> RUN with all enables 1.
- Saturation: force 70000 frozen cycles -> stall_count=16'hFFFF and holds.
- Async reset mid-WAIT: reset between clock edges -> state=00 and stall_count=0 immediately.
